// File: rtl/tx9_io10_pkg.sv
// Shared constants and types for the 9-lane x10 LVDS framer and its receive-side aligner.
package tx9_io10_pkg;

    localparam int LANES      = 9;
    localparam int DATA_LANES = 8;
    localparam int LANE_W     = 10;
    localparam int SEQ_W      = 9;
    localparam int CNT_W      = 16;

    typedef logic [LANE_W-1:0] word_t;

    typedef enum logic [1:0] {
        ST_TRAIN = 2'd0,
        ST_SYNC  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam word_t TRAIN_WORD = 10'h3E0;
    localparam word_t SYNC_WORD  = 10'h17C;
    localparam word_t IDLE_WORD  = 10'h2AA;

    // Lane 8 carries a payload marker bit on top of the 9-bit sequence number.
    function automatic word_t mark_word(input logic accepted, input logic [SEQ_W-1:0] seq);
        return {accepted, seq};
    endfunction

endpackage

// File: rtl/tx9_io10_framer_if.sv
// Payload handshake into the framer: 8 lanes of data, valid, and ready.
interface tx9_io10_framer_if;
    import tx9_io10_pkg::*;

    logic [DATA_LANES*LANE_W-1:0] I_data;
    logic                         I_valid;
    logic                         O_ready;

    modport master (output I_data, output I_valid, input O_ready);
    modport slave  (input I_data, input I_valid, output O_ready);
endinterface

// File: rtl/tx9_io10_seq.sv
// Link sequencer: TRAIN -> SYNC -> RUN FSM, run-length counter, payload sequence number.
module tx9_io10_seq
    import tx9_io10_pkg::*;
#(
    parameter int unsigned TRAIN_LEN = 256,
    parameter int unsigned SYNC_LEN  = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             train_req,
    input  logic             valid,
    output state_t           state,
    output state_t           state_next,
    output logic [SEQ_W-1:0] seq,
    output logic             ready,
    output logic             accept
);

    localparam logic [CNT_W-1:0] TRAIN_LAST = CNT_W'(TRAIN_LEN - 1);
    localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(SYNC_LEN - 1);

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [SEQ_W-1:0] seq_reg, seq_next;
    logic             primed_reg;

    // state_reg always names the state of the word currently on the output lanes.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg  <= ST_TRAIN;
            cnt_reg    <= '0;
            seq_reg    <= '0;
            primed_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            seq_reg    <= seq_next;
            primed_reg <= 1'b1;
        end
    end

    // cnt_reg is the index of the current word within its TRAIN/SYNC run; the
    // reset cycle outputs zeros, so the first edge out of reset starts index 0.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CNT_W'(1);
        case (state_reg)
            ST_TRAIN: begin
                if (train_req || !primed_reg) begin
                    cnt_next = '0;
                end else if (cnt_reg == TRAIN_LAST) begin
                    state_next = ST_SYNC;
                    cnt_next   = '0;
                end
            end
            ST_SYNC: begin
                if (train_req) begin
                    state_next = ST_TRAIN;
                    cnt_next   = '0;
                end else if (cnt_reg == SYNC_LAST) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end
            end
            ST_RUN: begin
                cnt_next = '0;
                if (train_req) begin
                    state_next = ST_TRAIN;
                end
            end
            default: begin
                state_next = ST_TRAIN;
                cnt_next   = '0;
            end
        endcase
        seq_next = (state_next == ST_TRAIN) ? '0 :
                   accept                   ? seq_reg + SEQ_W'(1) : seq_reg;
    end

    always_comb begin
        ready  = (state_reg == ST_RUN) && !train_req;
        accept = ready && valid;
        state  = state_reg;
        seq    = seq_reg;
    end

endmodule

// File: rtl/tx9_io10_framer.sv
// 9-lane x10 framer: lane word selection and output registers around the link sequencer.
module tx9_io10_framer
    import tx9_io10_pkg::*;
#(
    parameter int unsigned TRAIN_LEN = 256,
    parameter int unsigned SYNC_LEN  = 4
) (
    input  logic                I_clk,
    input  logic                I_rst,
    input  logic                I_train_req,
    tx9_io10_framer_if.slave    pay,
    output logic [LANE_W-1:0]   o0_p,
    output logic [LANE_W-1:0]   o1_p,
    output logic [LANE_W-1:0]   o2_p,
    output logic [LANE_W-1:0]   o3_p,
    output logic [LANE_W-1:0]   o4_p,
    output logic [LANE_W-1:0]   o5_p,
    output logic [LANE_W-1:0]   o6_p,
    output logic [LANE_W-1:0]   o7_p,
    output logic [LANE_W-1:0]   o8_p,
    output logic [1:0]          O_state,
    output logic                O_tx_active
);

    state_t           state, state_next;
    logic [SEQ_W-1:0] seq;
    logic             ready, accept;
    word_t            lane_q [LANES];

    tx9_io10_seq #(
        .TRAIN_LEN (TRAIN_LEN),
        .SYNC_LEN  (SYNC_LEN)
    ) u_seq (
        .clk        (I_clk),
        .srst       (I_rst),
        .train_req  (I_train_req),
        .valid      (pay.I_valid),
        .state      (state),
        .state_next (state_next),
        .seq        (seq),
        .ready      (ready),
        .accept     (accept)
    );

    assign pay.O_ready = ready;

    // Words are chosen from the state being entered so state and lane contents stay aligned.
    for (genvar gi = 0; gi < DATA_LANES; gi++) begin : g_data_lane
        word_t word_next, word_reg;

        always_comb begin
            case (state_next)
                ST_SYNC: word_next = SYNC_WORD;
                ST_RUN:  word_next = accept ? pay.I_data[gi*LANE_W +: LANE_W] : IDLE_WORD;
                default: word_next = TRAIN_WORD;
            endcase
        end

        always_ff @(posedge I_clk) begin
            if (I_rst) word_reg <= '0;
            else       word_reg <= word_next;
        end

        assign lane_q[gi] = word_reg;
    end

    word_t mark_next, mark_reg;

    always_comb begin
        case (state_next)
            ST_SYNC: mark_next = SYNC_WORD;
            ST_RUN:  mark_next = mark_word(accept, seq);
            default: mark_next = TRAIN_WORD;
        endcase
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) mark_reg <= '0;
        else       mark_reg <= mark_next;
    end

    assign lane_q[DATA_LANES] = mark_reg;

    assign o0_p = lane_q[0];
    assign o1_p = lane_q[1];
    assign o2_p = lane_q[2];
    assign o3_p = lane_q[3];
    assign o4_p = lane_q[4];
    assign o5_p = lane_q[5];
    assign o6_p = lane_q[6];
    assign o7_p = lane_q[7];
    assign o8_p = lane_q[8];

    assign O_state     = state;
    assign O_tx_active = (state == ST_RUN);

endmodule

// File: tb/tb_tx9_io10_framer.sv
// Directed bench for tx9_io10_framer with TRAIN_LEN=8, SYNC_LEN=2.
module tb_tx9_io10_framer;

    logic       clk = 1'b0;
    logic       rst;
    logic       train_req;
    logic [9:0] o0_p, o1_p, o2_p, o3_p, o4_p, o5_p, o6_p, o7_p, o8_p;
    logic [1:0] state;
    logic       tx_active;
    logic [9:0] outs [9];

    int checks = 0;
    int errors = 0;

    tx9_io10_framer_if pay();

    tx9_io10_framer #(
        .TRAIN_LEN (8),
        .SYNC_LEN  (2)
    ) dut (
        .I_clk       (clk),
        .I_rst       (rst),
        .I_train_req (train_req),
        .pay         (pay.slave),
        .o0_p        (o0_p),
        .o1_p        (o1_p),
        .o2_p        (o2_p),
        .o3_p        (o3_p),
        .o4_p        (o4_p),
        .o5_p        (o5_p),
        .o6_p        (o6_p),
        .o7_p        (o7_p),
        .o8_p        (o8_p),
        .O_state     (state),
        .O_tx_active (tx_active)
    );

    always #5 clk = ~clk;

    assign outs[0] = o0_p;
    assign outs[1] = o1_p;
    assign outs[2] = o2_p;
    assign outs[3] = o3_p;
    assign outs[4] = o4_p;
    assign outs[5] = o5_p;
    assign outs[6] = o6_p;
    assign outs[7] = o7_p;
    assign outs[8] = o8_p;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Lane n of a payload built from base carries base + 64*n.
    function automatic logic [9:0] lane_of(input logic [9:0] base, input int n);
        return base + 10'(n * 64);
    endfunction

    function automatic logic [79:0] mk(input logic [9:0] base);
        logic [79:0] d;
        for (int n = 0; n < 8; n++) d[n*10 +: 10] = lane_of(base, n);
        return d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_fill(input string tag, input logic [9:0] w, input logic [1:0] st);
        for (int n = 0; n < 9; n++) chk($sformatf("%s.lane%0d", tag, n), 32'(outs[n]), 32'(w));
        chk({tag, ".state"}, 32'(state), 32'(st));
    endtask

    task automatic chk_run(input string tag, input logic is_data, input logic [9:0] base,
                           input logic [9:0] mark);
        for (int n = 0; n < 8; n++)
            chk($sformatf("%s.lane%0d", tag, n), 32'(outs[n]),
                32'(is_data ? lane_of(base, n) : 10'h2AA));
        chk({tag, ".lane8"}, 32'(outs[8]), 32'(mark));
        chk({tag, ".state"}, 32'(state), 32'd2);
        chk({tag, ".active"}, 32'(tx_active), 32'd1);
    endtask

    initial begin
        rst         = 1'b1;
        train_req   = 1'b0;
        pay.I_valid = 1'b0;
        pay.I_data  = '0;

        repeat (3) tick();
        chk_fill("reset", 10'h000, 2'd0);
        chk("reset.ready", 32'(pay.O_ready), 32'd0);
        chk("reset.active", 32'(tx_active), 32'd0);

        // Bring-up: 8 training words, 2 sync words, then idle in RUN.
        rst = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk_fill($sformatf("boot.train%0d", i), 10'h3E0, 2'd0);
            chk($sformatf("boot.train%0d.ready", i), 32'(pay.O_ready), 32'd0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            chk_fill($sformatf("boot.sync%0d", i), 10'h17C, 2'd1);
            chk($sformatf("boot.sync%0d.ready", i), 32'(pay.O_ready), 32'd0);
            tick();
        end
        chk_run("boot.run0", 1'b0, 10'h000, 10'h000);
        chk("boot.run0.ready", 32'(pay.O_ready), 32'd1);

        // Three back-to-back payload words.
        pay.I_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            pay.I_data = mk(10'(k));
            tick();
            chk_run($sformatf("b2b%0d", k), 1'b1, 10'(k), 10'h200 + 10'(k - 1));
        end
        pay.I_valid = 1'b0;
        tick();
        chk_run("b2b.idle", 1'b0, 10'h000, 10'h003);

        // Train request with valid also high: nothing accepted, training word next.
        pay.I_valid = 1'b1;
        pay.I_data  = mk(10'h055);
        train_req   = 1'b1;
        #1;
        chk("retrain.ready", 32'(pay.O_ready), 32'd0);
        tick();
        chk_fill("retrain.train0", 10'h3E0, 2'd0);
        train_req = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk_fill($sformatf("retrain.train%0d", i), 10'h3E0, 2'd0);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_fill($sformatf("retrain.sync%0d", i), 10'h17C, 2'd1);
        end
        tick();
        chk_run("retrain.run0", 1'b0, 10'h000, 10'h000);

        // 513 accepts: sequence number wraps from 511 back to 0.
        for (int k = 1; k <= 513; k++) begin
            pay.I_data = mk(10'(k));
            tick();
            chk_run($sformatf("acc%0d", k), 1'b1, 10'(k), 10'h200 | 10'((k - 1) % 512));
        end
        pay.I_valid = 1'b0;
        tick();
        chk_run("wrap.idle", 1'b0, 10'h000, 10'h001);

        // Request held: enter TRAIN, hold 5 more cycles, SYNC 8 cycles after release.
        train_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_fill($sformatf("hold.req%0d", i), 10'h3E0, 2'd0);
        end
        train_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_fill($sformatf("hold.train%0d", i), 10'h3E0, 2'd0);
            tick();
        end
        chk_fill("hold.sync0", 10'h17C, 2'd1);

        // Reset during the first SYNC cycle.
        rst = 1'b1;
        tick();
        chk_fill("midrst", 10'h000, 2'd0);
        chk("midrst.ready", 32'(pay.O_ready), 32'd0);
        chk("midrst.active", 32'(tx_active), 32'd0);
        rst = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            chk_fill($sformatf("rerst.train%0d", i), 10'h3E0, 2'd0);
            tick();
        end
        chk_fill("rerst.sync0", 10'h17C, 2'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
